// File: rtl/scancode_pkg.sv
// scancode_pkg
//   Shared definitions for the scancode scheduler slice: byte widths, the
//   PS/2 break prefix and the issue-FSM state encoding.
package scancode_pkg;

    localparam int SCANCODE_W = 8;
    localparam int KEYCODE_W  = 8;

    // Set 2 break prefix; it travels through the scheduler like any other byte.
    localparam logic [SCANCODE_W-1:0] BREAK_PREFIX = 8'hF0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_GAP
    } sched_state_e;

endpackage

// File: rtl/scancode_sched_if.sv
// scancode_sched_if
//   Handshake bundle around the scheduler.
//   Converter side : conv_strobe/conv_code out, conv_valid/conv_keycode back.
//   Consumer side  : kbd_ready/kbd_data out, kbd_ack back.
//   master = the scheduler, slave = converter plus consumer.
interface scancode_sched_if;
    import scancode_pkg::*;

    logic                  conv_strobe;
    logic [SCANCODE_W-1:0] conv_code;
    logic                  conv_valid;
    logic [KEYCODE_W-1:0]  conv_keycode;
    logic                  kbd_ready;
    logic [KEYCODE_W-1:0]  kbd_data;
    logic                  kbd_ack;

    modport master (
        output conv_strobe, conv_code, kbd_ready, kbd_data,
        input  conv_valid, conv_keycode, kbd_ack
    );

    modport slave (
        input  conv_strobe, conv_code, kbd_ready, kbd_data,
        output conv_valid, conv_keycode, kbd_ack
    );

endinterface

// File: rtl/scancode_fifo.sv
// scancode_fifo
//   DEPTH-entry byte FIFO with registered occupancy.
//   Ports: clk, reset (async, active-low), push/wdata, pop/rdata (head is
//   shown combinationally), full, empty, drop (push refused), level.
//   A push while full is accepted only if a pop happens in the same cycle.
module scancode_fifo
    import scancode_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int LW    = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic [SCANCODE_W-1:0] wdata,
    input  logic                  pop,
    output logic [SCANCODE_W-1:0] rdata,
    output logic                  full,
    output logic                  empty,
    output logic                  drop,
    output logic [LW-1:0]         level
);

    localparam int AW = $clog2(DEPTH);

    logic [SCANCODE_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]         count_q,  count_d;
    logic                  push_ok, pop_ok;

    assign full    = (count_q == LW'(DEPTH));
    assign empty   = (count_q == '0);
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign drop    = push && !push_ok;
    assign rdata   = mem_q[rd_ptr_q];
    assign level   = count_q;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        // DEPTH is a power of two, so pointer overflow is the modulo wrap.
        if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + LW'(1);
            2'b01:   count_d = count_q - LW'(1);
            default: count_d = count_q;
        endcase
    end

    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is deliberately not reset; the pointers alone decide what is valid.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/scancode_sched.sv
// scancode_sched
//   Paces raw PS/2 scancodes into scancode_convert and holds each keycode
//   until the consumer acknowledges it.
//   Ports: clk, reset (async, active-low), ps2_strobe/ps2_code (byte in),
//   bus (converter + consumer handshakes), overrun/clear_overrun (sticky
//   loss flag), fifo_level (buffered byte count).
module scancode_sched
    import scancode_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int GAP   = 100,
    parameter int LW    = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ps2_strobe,
    input  logic [SCANCODE_W-1:0] ps2_code,
    scancode_sched_if.master      bus,
    output logic                  overrun,
    input  logic                  clear_overrun,
    output logic [LW-1:0]         fifo_level
);

    localparam int            CW       = $clog2(GAP + 1);
    localparam logic [CW-1:0] GAP_LOAD = CW'(GAP);

    sched_state_e          state_q;
    logic [CW-1:0]         cnt_q;
    logic                  conv_strobe_q;
    logic [SCANCODE_W-1:0] conv_code_q;
    logic                  kbd_ready_q, kbd_ready_d;
    logic [KEYCODE_W-1:0]  kbd_data_q,  kbd_data_d;
    logic                  overrun_q,   overrun_d;

    logic                  fifo_pop, fifo_full, fifo_empty, fifo_drop;
    logic [SCANCODE_W-1:0] fifo_head;
    logic                  kbd_lost;

    // Back-pressure: only pull a new byte when the output slot is free or is
    // being freed this very cycle.
    assign fifo_pop = (state_q == ST_IDLE) && !fifo_empty &&
                      (!kbd_ready_q || bus.kbd_ack);

    scancode_fifo #(
        .DEPTH (DEPTH),
        .LW    (LW)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (ps2_strobe),
        .wdata (ps2_code),
        .pop   (fifo_pop),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .drop  (fifo_drop),
        .level (fifo_level)
    );

    // The counter is loaded on the pop and runs down through ISSUE and GAP;
    // leaving when it reaches 0 makes strobes exactly GAP+1 clocks apart
    // under continuous demand.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            conv_strobe_q <= 1'b0;
            conv_code_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    conv_strobe_q <= 1'b0;
                    if (fifo_pop) begin
                        conv_code_q <= fifo_head;
                        cnt_q       <= GAP_LOAD;
                        state_q     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    conv_strobe_q <= 1'b1;
                    cnt_q         <= cnt_q - CW'(1);
                    state_q       <= (cnt_q == CW'(1)) ? ST_IDLE : ST_GAP;
                end
                ST_GAP: begin
                    conv_strobe_q <= 1'b0;
                    cnt_q         <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) state_q <= ST_IDLE;
                end
                default: begin
                    conv_strobe_q <= 1'b0;
                    cnt_q         <= '0;
                    state_q       <= ST_IDLE;
                end
            endcase
        end
    end

    // An ack in the same cycle as a new keycode frees the slot for the new
    // one, so that case is not a loss.
    always_comb begin
        kbd_ready_d = kbd_ready_q;
        kbd_data_d  = kbd_data_q;
        kbd_lost    = 1'b0;
        if (bus.conv_valid) begin
            kbd_data_d  = bus.conv_keycode;
            kbd_ready_d = 1'b1;
            kbd_lost    = kbd_ready_q && !bus.kbd_ack;
        end else if (bus.kbd_ack) begin
            kbd_ready_d = 1'b0;
        end
    end

    // A new loss wins over a clear arriving in the same cycle.
    always_comb begin
        overrun_d = overrun_q;
        if (fifo_drop || kbd_lost) overrun_d = 1'b1;
        else if (clear_overrun)    overrun_d = 1'b0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            kbd_ready_q <= 1'b0;
            kbd_data_q  <= '0;
            overrun_q   <= 1'b0;
        end else begin
            kbd_ready_q <= kbd_ready_d;
            kbd_data_q  <= kbd_data_d;
            overrun_q   <= overrun_d;
        end
    end

    assign bus.conv_strobe = conv_strobe_q;
    assign bus.conv_code   = conv_code_q;
    assign bus.kbd_ready   = kbd_ready_q;
    assign bus.kbd_data    = kbd_data_q;
    assign overrun         = overrun_q;

endmodule

// File: tb/tb_scancode_sched.sv
// tb_scancode_sched
//   Directed stimulus; expected conv_strobe codes and their arrival cycles
//   are queued as stimulus is issued and a monitor compares them against
//   every strobe the DUT produces.
module tb_scancode_sched;
    import scancode_pkg::*;

    localparam int DEPTH = 8;
    localparam int G     = 100;
    localparam int LW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          ps2_strobe = 1'b0;
    logic [7:0]    ps2_code = 8'h00;
    logic          overrun;
    logic          clear_overrun = 1'b0;
    logic [LW-1:0] fifo_level;

    scancode_sched_if bus ();

    scancode_sched #(
        .DEPTH (DEPTH),
        .GAP   (G),
        .LW    (LW)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .ps2_strobe    (ps2_strobe),
        .ps2_code      (ps2_code),
        .bus           (bus),
        .overrun       (overrun),
        .clear_overrun (clear_overrun),
        .fifo_level    (fifo_level)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  code;
        int unsigned cyc;
    } exp_t;

    exp_t        exp_q[$];
    int unsigned cyc = 0;
    int          n_checks = 0;
    int          n_pass = 0;
    int unsigned peak = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    endtask

    // Monitor: every strobe must match the head of the expectation queue.
    always @(negedge clk) begin
        exp_t e;
        if (reset && bus.conv_strobe) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_strobe: code 0x%0h at cycle %0d, none expected",
                         bus.conv_code, cyc);
            end else begin
                e = exp_q.pop_front();
                check("strobe_code", 32'(bus.conv_code), 32'(e.code));
                check("strobe_cycle", cyc, e.cyc);
            end
        end
        if (32'(fifo_level) > peak) peak = 32'(fifo_level);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic push_byte(input logic [7:0] b);
        ps2_code   = b;
        ps2_strobe = 1'b1;
        step();
        ps2_strobe = 1'b0;
    endtask

    task automatic keycode(input logic [7:0] k, input logic ack, input logic clr);
        bus.conv_valid   = 1'b1;
        bus.conv_keycode = k;
        bus.kbd_ack      = ack;
        clear_overrun    = clr;
        step();
        bus.conv_valid   = 1'b0;
        bus.kbd_ack      = 1'b0;
        clear_overrun    = 1'b0;
    endtask

    task automatic wait_drain(input int max_cycles);
        for (int i = 0; i < max_cycles && exp_q.size() != 0; i++) step();
        check("drain", exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        int unsigned c;
        bus.conv_valid   = 1'b0;
        bus.conv_keycode = 8'h00;
        bus.kbd_ack      = 1'b0;

        // Reset state
        repeat (3) step();
        check("rst_conv_strobe", 32'(bus.conv_strobe), 0);
        check("rst_conv_code",   32'(bus.conv_code),   0);
        check("rst_kbd_ready",   32'(bus.kbd_ready),   0);
        check("rst_kbd_data",    32'(bus.kbd_data),    0);
        check("rst_overrun",     32'(overrun),         0);
        check("rst_fifo_level",  32'(fifo_level),      0);
        reset = 1'b1;
        repeat (20) step();
        check("idle_fifo_level", 32'(fifo_level), 0);

        // Burst of three bytes: first strobe two edges after the push edge,
        // then one every G+1 clocks.
        peak = 0;
        c = cyc;
        exp_q.push_back('{8'h1C,        c + 3});
        exp_q.push_back('{BREAK_PREFIX, c + 3 + (G + 1)});
        exp_q.push_back('{8'h1C,        c + 3 + 2 * (G + 1)});
        push_byte(8'h1C);
        push_byte(BREAK_PREFIX);
        push_byte(8'h1C);
        wait_drain(3 * (G + 1) + 10);
        check("burst_peak_level", peak, 2);
        repeat (G + 5) step();

        // Hold-off: pending keycode blocks issue until acked.
        keycode(8'h41, 1'b0, 1'b0);
        check("hold_kbd_ready", 32'(bus.kbd_ready), 1);
        check("hold_kbd_data",  32'(bus.kbd_data),  32'h41);
        push_byte(8'h32);
        repeat (20) step();
        check("hold_kbd_ready2", 32'(bus.kbd_ready), 1);
        check("hold_kbd_data2",  32'(bus.kbd_data),  32'h41);
        check("hold_fifo_level", 32'(fifo_level),    1);
        c = cyc;
        exp_q.push_back('{8'h32, c + 2});
        bus.kbd_ack = 1'b1;
        step();
        bus.kbd_ack = 1'b0;
        check("ack_kbd_ready", 32'(bus.kbd_ready), 0);
        check("ack_kbd_data",  32'(bus.kbd_data),  32'h41);
        check("ack_fifo_level", 32'(fifo_level),   0);
        wait_drain(10);
        repeat (G + 5) step();

        // Overrun: FIFO fills while the slot is held, ninth byte dropped.
        keycode(8'h55, 1'b0, 1'b0);
        check("pre_overrun", 32'(overrun), 0);
        for (int i = 1; i <= 9; i++) push_byte(8'(i));
        check("full_fifo_level", 32'(fifo_level), DEPTH);
        check("full_overrun",    32'(overrun),    1);
        clear_overrun = 1'b1;
        step();
        clear_overrun = 1'b0;
        check("clr_overrun",    32'(overrun),    0);
        check("clr_fifo_level", 32'(fifo_level), DEPTH);
        c = cyc;
        for (int k = 0; k < DEPTH; k++) exp_q.push_back('{8'(k + 1), c + 2 + k * (G + 1)});
        bus.kbd_ack = 1'b1;
        step();
        bus.kbd_ack = 1'b0;
        check("drain_kbd_ready", 32'(bus.kbd_ready), 0);
        wait_drain(DEPTH * (G + 1) + 10);
        repeat (G + 5) step();

        // Ack/valid collision and set-over-clear priority.
        keycode(8'h60, 1'b0, 1'b0);
        keycode(8'h42, 1'b1, 1'b0);
        check("coll_kbd_ready", 32'(bus.kbd_ready), 1);
        check("coll_kbd_data",  32'(bus.kbd_data),  32'h42);
        check("coll_overrun",   32'(overrun),       0);
        keycode(8'h43, 1'b0, 1'b1);
        check("prio_overrun",  32'(overrun),      1);
        check("prio_kbd_data", 32'(bus.kbd_data), 32'h43);
        clear_overrun = 1'b1;
        step();
        clear_overrun = 1'b0;
        check("prio_clear", 32'(overrun), 0);
        bus.kbd_ack = 1'b1;
        step();
        bus.kbd_ack = 1'b0;
        check("final_ack_ready", 32'(bus.kbd_ready), 0);

        // Mid-gap reset: queued bytes and the running gap are discarded.
        c = cyc;
        exp_q.push_back('{8'h77, c + 3});
        push_byte(8'h77);
        wait_drain(10);
        repeat (10) step();
        push_byte(8'h11);
        push_byte(8'h22);
        check("gap_fifo_level", 32'(fifo_level), 2);
        reset = 1'b0;
        #1;
        check("mrst_fifo_level",  32'(fifo_level),      0);
        check("mrst_conv_strobe", 32'(bus.conv_strobe), 0);
        check("mrst_conv_code",   32'(bus.conv_code),   0);
        repeat (3) step();
        reset = 1'b1;
        c = cyc;
        exp_q.push_back('{8'h5A, c + 3});
        push_byte(8'h5A);
        wait_drain(10);
        repeat (G + 5) step();
        check("end_fifo_level", 32'(fifo_level), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/scancode_sched.md
Name: scancode_sched

Overview:
Scheduler between the PS/2 byte receiver and scancode_convert.
- Buffers raw scancode bytes in a small FIFO.
- Issues them to the converter one at a time, with a guaranteed idle gap between strobes.
- Holds each converted keycode in a single-entry output register until the consumer (CPU/bus side) acknowledges it.
- Applies back-pressure by not issuing new scancodes while an unread keycode is pending. Reports drops with a sticky overrun flag.

Parameters:
DEPTH, 8, scancode FIFO entries; power of two, ≥2
GAP, 100, minimum idle clocks after each conv_strobe pulse; ≥1
LW, 4, fifo_level width, equal to $clog2(DEPTH+1)

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-low reset
ps2_strobe  in  1  one-cycle pulse: ps2_code valid
ps2_code  in  8  raw scancode byte from PS/2 receiver
conv_strobe  out  1  one-cycle strobe to scancode_convert strobe_in
conv_code  out  8  scancode to scancode_convert code_in
conv_valid  in  1  scancode_convert strobe_out
conv_keycode  in  8  scancode_convert keycode
kbd_ready  out  1  keycode pending
kbd_data  out  8  pending keycode
kbd_ack  in  1  consumer pops pending keycode (ignored when kbd_ready=0)
overrun  out  1  sticky: scancode or keycode lost
clear_overrun  in  1  clears overrun
fifo_level  out  LW  current FIFO occupancy

Behaviour:
- Reset (reset=0, asynchronous): all outputs 0, FIFO empty, FSM in IDLE, gap counter 0. All outputs are registered.
- FIFO push: on ps2_strobe when not full, or when full and a pop occurs in the same cycle.
  - Push while full without pop: byte dropped, overrun←1.
  - Order preserved; pointers wrap modulo DEPTH.
- FSM IDLE: if FIFO non-empty AND (kbd_ready=0 OR kbd_ack=1), pop the head and go to ISSUE.
- FSM ISSUE: conv_strobe=1 and conv_code=popped byte for exactly one cycle, then go to GAP. Counter is loaded with GAP.
- FSM GAP: decrement each cycle; at 0 return to IDLE.
  - Consecutive conv_strobe pulses are ≥GAP+1 clocks apart (edge to edge).
  - conv_code holds its last value outside ISSUE.
- Latency, FIFO empty and FSM idle: ps2_strobe sampled at edge t → conv_strobe high in the cycle after edge t+2.
- Keycode capture: on conv_valid, kbd_data←conv_keycode and kbd_ready←1.
  - kbd_ack alone: kbd_ready←0, kbd_data retained.
  - conv_valid with kbd_ack in the same cycle: new data loaded, kbd_ready stays 1, no overrun.
  - conv_valid while kbd_ready=1 and no ack: data overwritten, overrun←1.
- Bytes producing no keycode (e.g. 0xF0, modifier make codes) simply consume a gap slot.
- overrun: set has priority over clear_overrun when both occur in the same cycle.
- fifo_level: updated the cycle after push/pop; simultaneous push+pop leaves it unchanged.
- Reset mid-operation: an in-flight conv_strobe is deasserted immediately and the remaining gap is abandoned.

Decomposition:
- Package scancode_pkg: FSM state enum (IDLE, ISSUE, GAP), SCANCODE_W=8, KEYCODE_W=8, BREAK_PREFIX=8'hF0.
- Sub-module scancode_fifo (DEPTH, 8-bit): push/pop/full/empty/level, same asynchronous active-low reset.
- FSM, gap counter and output register stay in scancode_sched.

Test Plan:
- Reset: hold reset=0 for 3 clocks, all outputs 0; release, idle 20 clocks → conv_strobe never asserted, fifo_level=0.
- Burst: ps2_strobe with 0x1C, 0xF0, 0x1C on 3 consecutive clocks → conv_strobe pulses carry 0x1C, 0xF0, 0x1C in order, exactly GAP+1 clocks apart; first pulse at t+3; fifo_level peaks at 2.
- Hold-off: converter model returns 0x41 on conv_valid, kbd_ack withheld, then push 0x32 → kbd_ready=1, kbd_data=0x41, no conv_strobe. Ack → 0x32 issued in the cycle after the next edge.
- Overrun: with kbd_ready=1 and no ack, push 9 bytes → fifo_level=8, overrun=1. clear_overrun → overrun=0, FIFO contents intact.
- Ack collision: kbd_ack and conv_valid (0x42) in the same cycle → kbd_ready stays 1, kbd_data=0x42, overrun=0.
- Mid-gap reset: assert reset 10 clocks into GAP → FIFO empty, state IDLE. After release, push 0x5A → conv_strobe at t+3, not delayed by the old gap.
